// File: rtl/read_miss_issuer_if.sv
`default_nettype none
// ============================================================================
//  Module      : read_miss_issuer_if
//  Description : Bundle of the tag-lookup miss handshake, the R_MISS_FIFO
//                write port, the CXL read-address channel and the
//                retirement/status signals of the read-miss issuer.
//                slave  : the issuer side
//                master : the environment (tag lookup, FIFO, CXL, return path)
//  Revision    : 1.0 - initial release
// ============================================================================
interface read_miss_issuer_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
);
    // Miss intake from tag lookup
    logic                  miss_valid_i;
    logic                  miss_ready_o;
    logic [ADDR_WIDTH-1:0] miss_addr_i;

    // R_MISS_FIFO write port
    logic                  fifo_write_en_o;
    logic                  fifo_full_i;
    logic [ADDR_WIDTH-1:0] fifo_wdata_o;

    // CXL read-address channel
    logic                  cxl_arvalid_o;
    logic                  cxl_arready_i;
    logic [ADDR_WIDTH-1:0] cxl_araddr_o;

    // Retirement and status
    logic                  resp_done_i;
    logic [CNT_WIDTH-1:0]  outstanding_o;
    logic                  err_underflow_o;

    modport slave (
        input  miss_valid_i,
        output miss_ready_o,
        input  miss_addr_i,
        output fifo_write_en_o,
        input  fifo_full_i,
        output fifo_wdata_o,
        output cxl_arvalid_o,
        input  cxl_arready_i,
        output cxl_araddr_o,
        input  resp_done_i,
        output outstanding_o,
        output err_underflow_o
    );

    modport master (
        output miss_valid_i,
        input  miss_ready_o,
        output miss_addr_i,
        input  fifo_write_en_o,
        output fifo_full_i,
        input  fifo_wdata_o,
        input  cxl_arvalid_o,
        output cxl_arready_i,
        input  cxl_araddr_o,
        output resp_done_i,
        input  outstanding_o,
        input  err_underflow_o
    );
endinterface
`default_nettype wire

// File: rtl/read_miss_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : read_miss_issuer
//  Description : Request side of the read-miss path. Each accepted miss is
//                pushed into R_MISS_FIFO in the same cycle its read request
//                is raised to the CXL controller, so the return path always
//                finds the matching address at the FIFO head. A credit
//                counter of pushed-but-not-retired misses gates acceptance
//                so neither the FIFO nor the controller is oversubscribed.
//                MAX_OUTSTANDING must lie in 1..R_MISS_FIFO depth.
//  Revision    : 1.0 - initial release
// ============================================================================
module read_miss_issuer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  wire                 clk,
    input  wire                 rst_n,
    read_miss_issuer_if.slave   bus
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_zero = '0;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [ADDR_WIDTH-1:0]  w_addr_next;
    logic                   r_fifo_we;
    logic                   w_fifo_we_next;
    logic                   r_arvalid;
    logic                   w_arvalid_next;

    logic [CNT_WIDTH-1:0]   r_outstanding;
    logic [CNT_WIDTH-1:0]   w_outstanding_next;
    logic                   r_err_underflow;
    logic                   w_err_underflow_next;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_retire;

    // Acceptance gate: idle, a credit is free and the FIFO has room.
    // Qualified with rst_n so the tag stage never sees ready during reset.
    always_comb begin
        w_ready  = rst_n
                && (r_state == S_IDLE)
                && (r_outstanding < c_cnt_max)
                && !bus.fifo_full_i;
        w_accept = bus.miss_valid_i && w_ready;
        w_retire = bus.resp_done_i;
    end

    // FSM next-state and registered-output next values.
    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_addr;
        w_fifo_we_next = 1'b0;
        w_arvalid_next = r_arvalid;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_addr_next    = bus.miss_addr_i;
                    w_fifo_we_next = 1'b1;
                    w_arvalid_next = 1'b1;
                    w_state_next   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Push is a single pulse; the request is held until taken.
                if (r_arvalid && bus.cxl_arready_i) begin
                    w_arvalid_next = 1'b0;
                    w_state_next   = S_IDLE;
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_arvalid_next = 1'b0;
            end
        endcase
    end

    // FSM state and request/push registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_fifo_we <= 1'b0;
            r_arvalid <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_addr    <= w_addr_next;
            r_fifo_we <= w_fifo_we_next;
            r_arvalid <= w_arvalid_next;
        end
    end

    // Credit counter: +1 on the push cycle, -1 on retirement, net zero when
    // both coincide. A retirement with nothing in flight is flagged and the
    // count is left at zero rather than wrapping.
    always_comb begin
        w_outstanding_next   = r_outstanding;
        w_err_underflow_next = r_err_underflow;
        if (r_fifo_we && !w_retire) begin
            w_outstanding_next = r_outstanding + c_cnt_one;
        end else if (!r_fifo_we && w_retire) begin
            if (r_outstanding == c_cnt_zero) begin
                w_err_underflow_next = 1'b1;
            end else begin
                w_outstanding_next = r_outstanding - c_cnt_one;
            end
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outstanding   <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            r_outstanding   <= w_outstanding_next;
            r_err_underflow <= w_err_underflow_next;
        end
    end

    // FIFO data and request address are the same captured register, so the
    // FIFO entry and the request can never disagree.
    always_comb begin
        bus.miss_ready_o    = w_ready;
        bus.fifo_write_en_o = r_fifo_we;
        bus.fifo_wdata_o    = r_addr;
        bus.cxl_arvalid_o   = r_arvalid;
        bus.cxl_araddr_o    = r_addr;
        bus.outstanding_o   = r_outstanding;
        bus.err_underflow_o = r_err_underflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_read_miss_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_read_miss_issuer
//  Description : Self-checking bench for read_miss_issuer. A cycle model
//                predicts every output; accepted addresses are queued and
//                matched against FIFO pushes and AR handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_read_miss_issuer;

    localparam int AW   = 32;
    localparam int MAXO = 8;
    localparam int CW   = $clog2(MAXO + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    read_miss_issuer_if #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW)) bus ();

    read_miss_issuer #(
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MAXO),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic          full;
        logic          arr;
        logic          done;
        logic          rn;
        logic          has_exp;
        logic          e_ready;
        logic          e_we;
        logic          e_arv;
        logic [AW-1:0] e_addr;
        int            e_cnt;
        logic          e_err;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    int n_push_seen  = 0;
    int n_arv_cycles = 0;

    logic [AW-1:0] push_q[$];
    logic [AW-1:0] ar_q[$];

    // Reference model state
    logic          m_we   = 1'b0;
    logic          m_arv  = 1'b0;
    logic [AW-1:0] m_addr = '0;
    int            m_cnt  = 0;
    logic          m_err  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: actual %0h required (no entry expected)", name, act);
    endtask

    function automatic vec_t mk(input logic v, input logic [AW-1:0] a, input logic full,
                                input logic arr, input logic done, input logic rn);
        vec_t t;
        t = '{v, a, full, arr, done, rn, 1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0};
        return t;
    endfunction

    task automatic go(input vec_t t);
        logic exp_ready;
        bus.miss_valid_i  = t.v;
        bus.miss_addr_i   = t.a;
        bus.fifo_full_i   = t.full;
        bus.cxl_arready_i = t.arr;
        bus.resp_done_i   = t.done;
        rst_n             = t.rn;
        exp_ready = t.rn && !m_arv && (m_cnt < MAXO) && !t.full;

        @(negedge clk);
        check("miss_ready",    bus.miss_ready_o,    exp_ready);
        check("fifo_write_en", bus.fifo_write_en_o, m_we);
        check("cxl_arvalid",   bus.cxl_arvalid_o,   m_arv);
        check("outstanding",   bus.outstanding_o,   m_cnt);
        check("err_underflow", bus.err_underflow_o, m_err);
        if (m_arv) check("cxl_araddr", bus.cxl_araddr_o, m_addr);
        if (t.has_exp) begin
            check("tbl_ready",       bus.miss_ready_o,    t.e_ready);
            check("tbl_we",          bus.fifo_write_en_o, t.e_we);
            check("tbl_arvalid",     bus.cxl_arvalid_o,   t.e_arv);
            check("tbl_outstanding", bus.outstanding_o,   t.e_cnt);
            check("tbl_err",         bus.err_underflow_o, t.e_err);
            if (t.e_arv) check("tbl_araddr", bus.cxl_araddr_o, t.e_addr);
            if (t.e_we)  check("tbl_wdata",  bus.fifo_wdata_o, t.e_addr);
        end
        if (bus.fifo_write_en_o === 1'b1) begin
            n_push_seen++;
            if (push_q.size() == 0) fail_now("push_unexpected", bus.fifo_wdata_o);
            else check("fifo_wdata", bus.fifo_wdata_o, push_q.pop_front());
        end
        if (bus.cxl_arvalid_o === 1'b1) begin
            n_arv_cycles++;
            if (t.arr) begin
                if (ar_q.size() == 0) fail_now("ar_unexpected", bus.cxl_araddr_o);
                else check("ar_handshake_addr", bus.cxl_araddr_o, ar_q.pop_front());
            end
        end

        @(posedge clk);
        if (!t.rn) begin
            m_we = 1'b0; m_arv = 1'b0; m_addr = '0; m_cnt = 0; m_err = 1'b0;
            push_q.delete();
            ar_q.delete();
        end else begin
            if (m_we && !t.done) m_cnt++;
            else if (!m_we && t.done) begin
                if (m_cnt == 0) m_err = 1'b1;
                else m_cnt--;
            end
            if (!m_arv) begin
                if (t.v && exp_ready) begin
                    m_addr = t.a; m_we = 1'b1; m_arv = 1'b1;
                    push_q.push_back(t.a);
                    ar_q.push_back(t.a);
                end
            end else begin
                m_we = 1'b0;
                if (t.arr) m_arv = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[5];
        int   n0;
        int   a0;
        logic [AW-1:0] addr;

        // Single miss at 0x1000 with arready tied high; hand-derived outputs.
        tbl[0] = '{1'b1, 32'h1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    0, 1'b0};
        tbl[1] = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000, 0, 1'b0};
        tbl[2] = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    1, 1'b0};
        tbl[3] = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    1, 1'b0};
        tbl[4] = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    0, 1'b0};

        bus.miss_valid_i  = 1'b0;
        bus.miss_addr_i   = '0;
        bus.fifo_full_i   = 1'b0;
        bus.cxl_arready_i = 1'b0;
        bus.resp_done_i   = 1'b0;
        rst_n             = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        go(mk(1'b1, 32'hdead, 1'b0, 1'b1, 1'b0, 1'b0));

        // Single miss
        for (int i = 0; i < 5; i++) go(tbl[i]);

        // arready low for five cycles
        n0 = n_push_seen;
        a0 = n_arv_cycles;
        go(mk(1'b1, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 5; i++) go(mk(1'b1, 32'h2abc, 1'b0, 1'b0, 1'b0, 1'b1));
        go(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        go(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        check("t2_push_count",     n_push_seen - n0,  1);
        check("t2_arvalid_cycles", n_arv_cycles - a0, 6);

        // Credit limit with back-to-back misses
        for (int k = 0; k < 16 && m_cnt > 0; k++) go(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1));
        for (int i = 0; i < 20; i++) begin
            addr = 32'h3000 + 32'(i * 16);
            go(mk(1'b1, addr, 1'b0, 1'b1, 1'b0, 1'b1));
        end
        check("t3_outstanding_limit", bus.outstanding_o, 8);
        check("t3_ready_at_limit",    bus.miss_ready_o,  1'b0);
        go(mk(1'b1, 32'h3f00, 1'b0, 1'b1, 1'b1, 1'b1));
        check("t3_outstanding_after_retire", bus.outstanding_o, 7);
        check("t3_ready_after_retire",       bus.miss_ready_o,  1'b1);
        go(mk(1'b1, 32'h4000, 1'b0, 1'b1, 1'b0, 1'b1));
        go(mk(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1));
        check("t3_outstanding_refill", bus.outstanding_o, 8);

        // Push and retire in the same cycle at 3, then underflow
        for (int k = 0; k < 16 && m_cnt != 3; k++) go(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1));
        go(mk(1'b1, 32'h5000, 1'b0, 1'b1, 1'b0, 1'b1));
        go(mk(1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 1'b1));
        go(mk(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1));
        check("t4_push_and_retire", bus.outstanding_o, 3);
        for (int k = 0; k < 16 && m_cnt > 0; k++) go(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1));
        go(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1));
        check("t4_underflow_count", bus.outstanding_o,   0);
        check("t4_underflow_flag",  bus.err_underflow_o, 1'b1);
        go(mk(1'b1, 32'h5100, 1'b0, 1'b1, 1'b0, 1'b1));
        go(mk(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1));
        go(mk(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1));
        check("t4_underflow_sticky", bus.err_underflow_o, 1'b1);

        // FIFO full blocks acceptance
        n0 = n_push_seen;
        for (int i = 0; i < 3; i++) go(mk(1'b1, 32'h6000, 1'b1, 1'b1, 1'b0, 1'b1));
        check("t5_no_push_when_full", n_push_seen - n0, 0);
        check("t5_ready_when_full",   bus.miss_ready_o, 1'b0);
        go(mk(1'b1, 32'h6000, 1'b0, 1'b1, 1'b0, 1'b1));
        go(mk(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1));
        check("t5_push_after_release", n_push_seen - n0, 1);

        // Reset while a request is pending
        go(mk(1'b1, 32'h7000, 1'b0, 1'b0, 1'b0, 1'b1));
        check("t6_arvalid_pending", bus.cxl_arvalid_o, 1'b1);
        go(mk(1'b1, 32'h7100, 1'b0, 1'b0, 1'b0, 1'b0));
        check("t6_arvalid_dropped",   bus.cxl_arvalid_o,   1'b0);
        check("t6_outstanding_clear", bus.outstanding_o,   0);
        check("t6_err_cleared",       bus.err_underflow_o, 1'b0);
        check("t6_ready_in_reset",    bus.miss_ready_o,    1'b0);
        go(mk(1'b1, 32'h7200, 1'b0, 1'b1, 1'b0, 1'b1));
        go(mk(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1));
        go(mk(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1));

        check("push_queue_drained", push_q.size(), 0);
        check("ar_queue_drained",   ar_q.size(),   0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
